// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hold/flush/redirect controller for the 5-stage core.
// Arbitrates bus-master freezes, multi-cycle EX holds, EX jumps and load-use
// interlocks. A jump seen while the core is frozen is parked and replayed on release.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int         JUMP_BUBBLES = 1,
    parameter logic [4:0] ZERO_REG     = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_reg_we_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        id_reg1_re_i,
    input  logic [4:0]  id_reg1_raddr_i,
    input  logic        id_reg2_re_i,
    input  logic [4:0]  id_reg2_raddr_i,
    input  logic        ex_hold_req_i,
    input  logic        bus_hold_req_i,
    output logic        bus_hold_ack_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_flag_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        EX_HOLD,
        BUS_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_bubbleCnt;
    logic [1:0]  w_nextBubbleCnt;
    logic        r_pendValid;
    logic        w_nextPendValid;
    logic [31:0] r_pendAddr;
    logic [31:0] w_nextPendAddr;
    logic        r_ack;

    logic        w_loadUse;
    logic        w_busHeld;
    logic        w_jumpNow;
    logic [31:0] w_jumpTarget;

    logic [2:0]  w_hold;
    logic        w_jumpFlag;
    logic [31:0] w_jumpAddr;
    logic        w_flushIfId;
    logic        w_flushIdEx;

    // The core stays frozen for the whole time the bus is granted, including the
    // cycle in which the request has dropped but the registered ack is still high.
    assign w_busHeld    = bus_hold_req_i | (r_state == BUS_HOLD);
    // A fresh jump is younger than a parked one, so it takes precedence.
    assign w_jumpNow    = jump_flag_i | r_pendValid;
    assign w_jumpTarget = jump_flag_i ? jump_addr_i : r_pendAddr;

    // Load-use detection: a load in EX writing a real register that ID reads.
    always_comb begin
        w_loadUse = ex_mem_rd_i & ex_reg_we_i & (ex_reg_waddr_i != ZERO_REG) &
                    ((id_reg1_re_i & (id_reg1_raddr_i == ex_reg_waddr_i)) |
                     (id_reg2_re_i & (id_reg2_raddr_i == ex_reg_waddr_i)));
    end

    // Priority arbitration producing next state and the combinational controls.
    always_comb begin
        w_nextState     = IDLE;
        w_nextBubbleCnt = 2'd0;
        w_nextPendValid = r_pendValid;
        w_nextPendAddr  = r_pendAddr;
        w_hold          = 3'd0;
        w_jumpFlag      = 1'b0;
        w_jumpAddr      = 32'd0;
        w_flushIfId     = 1'b0;
        w_flushIdEx     = 1'b0;

        if (rst) begin
            w_nextPendValid = 1'b0;
            w_nextPendAddr  = 32'd0;
        end else if (w_busHeld) begin
            w_hold      = 3'd3;
            w_nextState = bus_hold_req_i ? BUS_HOLD : IDLE;
            if (jump_flag_i) begin
                w_nextPendValid = 1'b1;
                w_nextPendAddr  = jump_addr_i;
            end
        end else if (ex_hold_req_i) begin
            w_hold      = 3'd3;
            w_nextState = EX_HOLD;
            if (jump_flag_i) begin
                w_nextPendValid = 1'b1;
                w_nextPendAddr  = jump_addr_i;
            end
        end else if (w_jumpNow) begin
            w_jumpFlag      = 1'b1;
            w_jumpAddr      = w_jumpTarget;
            w_flushIfId     = 1'b1;
            w_flushIdEx     = 1'b1;
            w_nextPendValid = 1'b0;
            w_nextPendAddr  = 32'd0;
            if (JUMP_BUBBLES > 0) begin
                w_nextState     = FLUSH;
                w_nextBubbleCnt = 2'(JUMP_BUBBLES);
            end
        end else if (r_state == FLUSH) begin
            // ID only holds a flushed bubble here, so load-use is not considered.
            w_flushIfId = 1'b1;
            if (r_bubbleCnt > 2'd1) begin
                w_nextState     = FLUSH;
                w_nextBubbleCnt = r_bubbleCnt - 2'd1;
            end
        end else if (w_loadUse) begin
            w_hold      = 3'd2;
            w_flushIdEx = 1'b1;
        end
    end

    // State, bubble counter, pending jump and registered bus acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bubbleCnt <= 2'd0;
            r_pendValid <= 1'b0;
            r_pendAddr  <= 32'd0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_bubbleCnt <= w_nextBubbleCnt;
            r_pendValid <= w_nextPendValid;
            r_pendAddr  <= w_nextPendAddr;
            r_ack       <= (w_nextState == BUS_HOLD);
        end
    end

    assign hold_flag_o    = w_hold;
    assign jump_flag_o    = w_jumpFlag;
    assign jump_addr_o    = w_jumpAddr;
    assign flush_if_id_o  = w_flushIfId;
    assign flush_id_ex_o  = w_flushIdEx;
    assign bus_hold_ack_o = r_ack & ~rst;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_flushCount;

    // Saturating counters of held cycles and issued redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= 32'd0;
            r_flushCount  <= 32'd0;
        end else begin
            if ((w_hold != 3'd0) && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (w_jumpFlag && (r_flushCount != 32'hFFFF_FFFF)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign stall_cycles_o = r_stallCycles;
    assign flush_count_o  = r_flushCount;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
// Each step drives one cycle of inputs, pushes the expected controls for that
// cycle, then pops and compares them mid-cycle. Counters are checked at the end.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        ex_mem_rd_i = 1'b0;
    logic        ex_reg_we_i = 1'b0;
    logic [4:0]  ex_reg_waddr_i = 5'd0;
    logic        id_reg1_re_i = 1'b0;
    logic [4:0]  id_reg1_raddr_i = 5'd0;
    logic        id_reg2_re_i = 1'b0;
    logic [4:0]  id_reg2_raddr_i = 5'd0;
    logic        ex_hold_req_i = 1'b0;
    logic        bus_hold_req_i = 1'b0;
    logic        bus_hold_ack_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;

    typedef struct packed {
        logic        rst;
        logic        jf;
        logic [31:0] ja;
        logic        memRd;
        logic        regWe;
        logic [4:0]  waddr;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        exHold;
        logic        busHold;
    } stim_t;

    typedef struct packed {
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] addr;
        logic        fIf;
        logic        fId;
        logic        ack;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    errors = 0;
    int    checks = 0;
    int    modelStall = 0;
    int    modelFlush = 0;

    pipe_hazard_ctrl #(
        .JUMP_BUBBLES (1),
        .ZERO_REG     (5'd0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .ex_mem_rd_i     (ex_mem_rd_i),
        .ex_reg_we_i     (ex_reg_we_i),
        .ex_reg_waddr_i  (ex_reg_waddr_i),
        .id_reg1_re_i    (id_reg1_re_i),
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_re_i    (id_reg2_re_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .ex_hold_req_i   (ex_hold_req_i),
        .bus_hold_req_i  (bus_hold_req_i),
        .bus_hold_ack_o  (bus_hold_ack_o),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o),
        .hold_flag_o     (hold_flag_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .stall_cycles_o  (stall_cycles_o),
        .flush_count_o   (flush_count_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mkExp(input int h, input int j, input int a,
                                   input int fi, input int fd, input int ak);
        exp_t e;
        e.hold = 3'(h);
        e.jf   = 1'(j);
        e.addr = 32'(a);
        e.fIf  = 1'(fi);
        e.fId  = 1'(fd);
        e.ack  = 1'(ak);
        return e;
    endfunction

    // Drive one cycle of inputs on the falling edge and record what must come out.
    task automatic applyStimulus(input stim_t s, input exp_t e, input string tag);
        @(negedge clk);
        rst             = s.rst;
        jump_flag_i     = s.jf;
        jump_addr_i     = s.ja;
        ex_mem_rd_i     = s.memRd;
        ex_reg_we_i     = s.regWe;
        ex_reg_waddr_i  = s.waddr;
        id_reg1_re_i    = s.re1;
        id_reg1_raddr_i = s.ra1;
        id_reg2_re_i    = s.re2;
        id_reg2_raddr_i = s.ra2;
        ex_hold_req_i   = s.exHold;
        bus_hold_req_i  = s.busHold;
        expQ.push_back(e);
        tagQ.push_back(tag);
        if (s.rst) begin
            modelStall = 0;
            modelFlush = 0;
        end else begin
            if (e.hold != 3'd0) modelStall++;
            if (e.jf) modelFlush++;
        end
    endtask

    // Pop the oldest expectation and compare against the settled outputs.
    task automatic checkOutput();
        exp_t  e;
        exp_t  obs;
        string tag;
        #2;
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        obs.hold = hold_flag_o;
        obs.jf   = jump_flag_o;
        obs.addr = jump_addr_o;
        obs.fIf  = flush_if_id_o;
        obs.fId  = flush_id_ex_o;
        obs.ack  = bus_hold_ack_o;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL %s: observed hold=%0d jf=%0b addr=%h fIf=%0b fId=%0b ack=%0b, expected hold=%0d jf=%0b addr=%h fIf=%0b fId=%0b ack=%0b",
                   tag, obs.hold, obs.jf, obs.addr, obs.fIf, obs.fId, obs.ack,
                   e.hold, e.jf, e.addr, e.fIf, e.fId, e.ack);
        end
    endtask

    task automatic step(input stim_t s, input exp_t e, input string tag);
        applyStimulus(s, e, tag);
        checkOutput();
    endtask

    initial begin
        stim_t       s;
        logic [31:0] expStall;
        logic [31:0] expFlush;

        // Reset and idle
        s = '0; s.rst = 1'b1;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "reset0");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "reset1");
        s = '0;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "idle_after_reset");

        // Reset in the middle of a bus hold with a parked jump
        s = '0; s.busHold = 1'b1;
        step(s, mkExp(3, 0, 0, 0, 0, 0), "rstbus_c0");
        step(s, mkExp(3, 0, 0, 0, 0, 1), "rstbus_c1");
        s.jf = 1'b1; s.ja = 32'h0000_0500;
        step(s, mkExp(3, 0, 0, 0, 0, 1), "rstbus_c2_jump");
        s = '0; s.rst = 1'b1;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "rstbus_c3_rst");
        s = '0;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "rstbus_c4_no_replay");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "rstbus_c5");

        // Load-use interlock variants
        s = '0; s.memRd = 1'b1; s.regWe = 1'b1; s.waddr = 5'd5; s.re2 = 1'b1; s.ra2 = 5'd5;
        step(s, mkExp(2, 0, 0, 0, 1, 0), "loaduse_rs2");
        s = '0;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "loaduse_rs2_done");
        s = '0; s.memRd = 1'b1; s.regWe = 1'b1; s.waddr = 5'd7; s.re1 = 1'b1; s.ra1 = 5'd7;
        step(s, mkExp(2, 0, 0, 0, 1, 0), "loaduse_rs1");
        s = '0; s.memRd = 1'b1; s.regWe = 1'b1; s.waddr = 5'd0; s.re2 = 1'b1; s.ra2 = 5'd0;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "loaduse_x0");
        s = '0; s.memRd = 1'b1; s.regWe = 1'b1; s.waddr = 5'd5; s.re2 = 1'b0; s.ra2 = 5'd5;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "loaduse_re_off");
        s = '0; s.memRd = 1'b0; s.regWe = 1'b1; s.waddr = 5'd5; s.re2 = 1'b1; s.ra2 = 5'd5;
        step(s, mkExp(0, 0, 0, 0, 0, 0), "not_a_load");

        // Plain jump with one bubble
        s = '0; s.jf = 1'b1; s.ja = 32'h0000_0100;
        step(s, mkExp(0, 1, 'h100, 1, 1, 0), "jump_c0");
        s = '0;
        step(s, mkExp(0, 0, 0, 1, 0, 0), "jump_c1");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "jump_c2");

        // Jump beats a simultaneous load-use
        s = '0; s.jf = 1'b1; s.ja = 32'h0000_0140;
        s.memRd = 1'b1; s.regWe = 1'b1; s.waddr = 5'd5; s.re2 = 1'b1; s.ra2 = 5'd5;
        step(s, mkExp(0, 1, 'h140, 1, 1, 0), "jump_vs_loaduse");
        s = '0;
        step(s, mkExp(0, 0, 0, 1, 0, 0), "jlu_c1");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "jlu_c2");

        // Jump during FLUSH restarts the redirect
        s = '0; s.jf = 1'b1; s.ja = 32'h0000_0180;
        step(s, mkExp(0, 1, 'h180, 1, 1, 0), "jif_c0");
        s.ja = 32'h0000_01C0;
        step(s, mkExp(0, 1, 'h1C0, 1, 1, 0), "jump_in_flush");
        s = '0;
        step(s, mkExp(0, 0, 0, 1, 0, 0), "jif_c2");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "jif_c3");

        // Multi-cycle EX hold with a parked jump replayed on release
        s = '0; s.exHold = 1'b1;
        step(s, mkExp(3, 0, 0, 0, 0, 0), "exhold_c0");
        step(s, mkExp(3, 0, 0, 0, 0, 0), "exhold_c1");
        s.jf = 1'b1; s.ja = 32'h0000_0200;
        step(s, mkExp(3, 0, 0, 0, 0, 0), "exhold_c2_jump");
        s.jf = 1'b0;
        step(s, mkExp(3, 0, 0, 0, 0, 0), "exhold_c3");
        s = '0;
        step(s, mkExp(0, 1, 'h200, 1, 1, 0), "exhold_release");
        step(s, mkExp(0, 0, 0, 1, 0, 0), "exhold_c5");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "exhold_c6");

        // Bus hold handshake with jump overwrite while frozen
        s = '0; s.busHold = 1'b1;
        step(s, mkExp(3, 0, 0, 0, 0, 0), "bus_c0");
        step(s, mkExp(3, 0, 0, 0, 0, 1), "bus_c1");
        s.jf = 1'b1; s.ja = 32'h0000_0400;
        step(s, mkExp(3, 0, 0, 0, 0, 1), "bus_c2_jump");
        s.ja = 32'h0000_0440;
        step(s, mkExp(3, 0, 0, 0, 0, 1), "bus_c3_jump2");
        s.jf = 1'b0;
        step(s, mkExp(3, 0, 0, 0, 0, 1), "bus_c4");
        s = '0;
        step(s, mkExp(3, 0, 0, 0, 0, 1), "bus_c5_release");
        step(s, mkExp(0, 1, 'h440, 1, 1, 0), "bus_c6_replay");
        step(s, mkExp(0, 0, 0, 1, 0, 0), "bus_c7");
        step(s, mkExp(0, 0, 0, 0, 0, 0), "bus_c8");

        // Performance counters after the last update edge
        @(posedge clk);
        #1;
`ifdef PIPE_CTRL_PERF_EN
        expStall = 32'(modelStall);
        expFlush = 32'(modelFlush);
`else
        expStall = 32'd0;
        expFlush = 32'd0;
`endif
        checks++;
        assert (stall_cycles_o === expStall) else begin
            errors++;
            $error("[TB] FAIL stall_cycles: observed=%0d expected=%0d", stall_cycles_o, expStall);
        end
        checks++;
        assert (flush_count_o === expFlush) else begin
            errors++;
            $error("[TB] FAIL flush_count: observed=%0d expected=%0d", flush_count_o, expFlush);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
